pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Owns the architectural program counter and runs instruction fetch. Drives PCResult into the
//  external PCAdder and takes PCAddResult back as the sequential next PC. Fetches each PC from
//  instruction memory over a req/ack handshake. Presents one fetched instruction at a time to
//  the IF/ID stage, with stall and branch/jump redirect support.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  WAIT_LIMIT  16             cycles without IMemAck before FetchErr is set (>=2)
// PORTS
//  Clk          in   1   system clock, rising edge
//  Reset        in   1   asynchronous, active-low reset
//  PCAddResult  in   32  PCResult+4 from external PCAdder (not checked here)
//  Redirect     in   1   branch/jump taken; one-cycle pulse, valid in any state
//  RedirectPC   in   32  redirect target; bits [1:0] forced to 2'b00
//  Stall        in   1   IF/ID cannot accept the presented instruction
//  IMemAck      in   1   memory returns IMemData this cycle (one-cycle pulse)
//  IMemData     in   32  instruction word, valid when IMemAck=1
//  PCResult     out  32  architectural PC (next PC to fetch); feeds PCAdder
//  IMemReq      out  1   fetch request
//  IMemAddr     out  32  address of the in-flight request
//  InstrValid   out  1   Instruction/InstrPC valid for IF/ID
//  Instruction  out  32  fetched instruction word
//  InstrPC      out  32  PC of Instruction
//  FetchErr     out  1   sticky: WAIT_LIMIT reached without ack
// BEHAVIOUR
//  Reset (async assert, sync release): PCResult=RESET_PC, IMemAddr=RESET_PC, IMemReq=0,
//   InstrValid=0, Instruction=0, InstrPC=0, FetchErr=0, wait counter=0, state=FETCH.
//   First cycle after release: IMemReq=1, IMemAddr=RESET_PC.
//  Handshake: IMemReq and IMemAddr stay stable from assertion until the cycle IMemAck=1
//   (inclusive). Ack is legal from the cycle after IMemReq rises. Ack outside a request is ignored.
//  States:
//   FETCH: IMemReq=1, IMemAddr=PCResult.
//    Ack & !Redirect: Instruction<=IMemData, InstrPC<=IMemAddr, InstrValid<=1,
//     PCResult<=PCAddResult, IMemReq<=0 -> HOLD.
//    Ack & Redirect: data discarded, PCResult<=RedirectPC, IMemAddr<=RedirectPC, stay FETCH.
//    Redirect & !Ack: PCResult<=RedirectPC, IMemAddr held -> DROP.
//   DROP: IMemReq=1 with the old IMemAddr. Later Redirect overwrites PCResult (last one wins).
//    On Ack: data discarded, IMemAddr<=PCResult -> FETCH.
//   HOLD: InstrValid=1; Instruction and InstrPC held stable.
//    Redirect: InstrValid<=0, PCResult<=RedirectPC, IMemAddr<=RedirectPC -> FETCH.
//     Redirect overrides Stall.
//    !Stall: instruction is consumed at this edge. InstrValid<=0,
//     IMemAddr<=PCResult -> FETCH.
//    Stall: stay in HOLD.
//  Throughput: no fetch overlap. With a 1-cycle ack, one instruction every 3 cycles.
//  Wait counter: increments each cycle in FETCH/DROP without Ack and clears on Ack or Redirect.
//   It saturates at WAIT_LIMIT. Reaching WAIT_LIMIT sets FetchErr, which is sticky until reset.
//   The request keeps waiting after FetchErr is set.
//  PC arithmetic: 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000 through PCAdder. No overflow flag.
//  Reset mid-operation: every output returns to its reset value immediately. An in-flight
//   memory ack arriving after reset is ignored.
// TESTING
//  1 Hold Reset=0, then release -> outputs at reset values. Next cycle IMemReq=1, IMemAddr=0.
//  2 Memory returns {addr} as data with a 1-cycle ack, Stall=0 -> one InstrValid pulse each for
//    InstrPC/Instruction 0x0,0x4,0x8,0xC in order, 3 cycles apart.
//  3 Stall=1 for 5 cycles in HOLD (InstrPC=0x4) -> InstrValid, Instruction and InstrPC stable,
//    IMemReq=0 throughout. After release, next IMemAddr=0x8.
//  4 Redirect to 0x40 while the request for 0x8 is unacked, ack 3 cycles later -> 0x8 data never
//    presented, IMemAddr=0x8 held until ack, then IMemAddr=0x40, then InstrPC=0x40.
//  5 Redirect to 0x43 during HOLD with Stall=1 -> InstrValid=0 next cycle, IMemAddr=0x40.
//    Redirect together with Ack in FETCH -> data dropped, next IMemAddr=target.
//  6 No ack for WAIT_LIMIT=16 cycles -> FetchErr=1 at cycle 16 and stays set after a later ack.
//    Reset pulsed mid-wait -> IMemReq=0 and FetchErr=0 without waiting for a clock edge.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter owner and single-outstanding instruction fetch engine.
// Issues one memory request at a time, presents the returned word to IF/ID,
// and handles stall, branch/jump redirect and a sticky fetch-timeout flag.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCAddResult,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Stall,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] PCResult,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic        InstrValid,
  output logic [31:0] Instruction,
  output logic [31:0] InstrPC,
  output logic        FetchErr
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DROP  = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   ipc_q, ipc_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [XLEN-1:0]   redir_tgt_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  // Word-aligned redirect target and saturating wait-counter increment
  always_comb begin
    redir_tgt_c = RedirectPC & 32'hFFFF_FFFC;
    cnt_inc_c   = (cnt_q == CNT_W'(WAIT_LIMIT)) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and next-output logic for the fetch sequencer
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    req_d   = req_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_FETCH: begin
        if (!req_q) begin
          // First cycle after reset: nothing in flight yet, so any ack is stale
          req_d = 1'b1;
          if (Redirect) begin
            pc_d   = redir_tgt_c;
            addr_d = redir_tgt_c;
          end
        end else if (IMemAck) begin
          cnt_d = '0;
          if (Redirect) begin
            pc_d   = redir_tgt_c;
            addr_d = redir_tgt_c;
          end else begin
            instr_d = IMemData;
            ipc_d   = addr_q;
            valid_d = 1'b1;
            pc_d    = PCAddResult;
            req_d   = 1'b0;
            state_d = ST_HOLD;
          end
        end else if (Redirect) begin
          // Request must stay stable until acked; its data will be dropped
          cnt_d   = '0;
          pc_d    = redir_tgt_c;
          state_d = ST_DROP;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      ST_DROP: begin
        if (IMemAck) begin
          cnt_d   = '0;
          state_d = ST_FETCH;
          if (Redirect) begin
            pc_d   = redir_tgt_c;
            addr_d = redir_tgt_c;
          end else begin
            addr_d = pc_q;
          end
        end else if (Redirect) begin
          cnt_d = '0;
          pc_d  = redir_tgt_c;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      ST_HOLD: begin
        if (Redirect) begin
          valid_d = 1'b0;
          pc_d    = redir_tgt_c;
          addr_d  = redir_tgt_c;
          req_d   = 1'b1;
          state_d = ST_FETCH;
        end else if (!Stall) begin
          valid_d = 1'b0;
          addr_d  = pc_q;
          req_d   = 1'b1;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Timeout flag is sticky once the counter saturates
  always_comb begin
    err_d = err_q | (cnt_d == CNT_W'(WAIT_LIMIT));
  end

  // State and output registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCResult    = pc_q;
  assign IMemReq     = req_q;
  assign IMemAddr    = addr_q;
  assign InstrValid  = valid_q;
  assign Instruction = instr_q;
  assign InstrPC     = ipc_q;
  assign FetchErr    = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed stimulus, a transaction-level model
// compared every cycle, plus literal expectations on key cycles.
module tb_pc_fetch_unit;

  localparam int unsigned LIMIT = 16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] PCAddResult;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        Stall = 1'b0;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = 32'h0;
  logic [31:0] PCResult;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        InstrValid;
  logic [31:0] Instruction;
  logic [31:0] InstrPC;
  logic        FetchErr;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  // External PC adder
  assign PCAddResult = PCResult + 32'd4;

  pc_fetch_unit #(.RESET_PC(32'h0), .WAIT_LIMIT(LIMIT)) dut (
    .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .Stall(Stall), .IMemAck(IMemAck), .IMemData(IMemData),
    .PCResult(PCResult), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .InstrValid(InstrValid),
    .Instruction(Instruction), .InstrPC(InstrPC), .FetchErr(FetchErr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: tracks what is in flight, what is presented,
  // and whether the in-flight response is stale.
  logic [31:0] m_pc, m_addr, m_instr, m_ipc;
  logic        m_req, m_valid, m_err, m_stale;
  int          m_wait;

  always @(posedge Clk or negedge Reset) begin
    logic [31:0] tgt;
    tgt = RedirectPC & 32'hFFFF_FFFC;
    if (!Reset) begin
      m_pc = 0; m_addr = 0; m_instr = 0; m_ipc = 0;
      m_req = 0; m_valid = 0; m_err = 0; m_stale = 0; m_wait = 0;
    end else if (m_valid) begin
      if (Redirect) begin
        m_valid = 0; m_pc = tgt; m_addr = tgt; m_req = 1;
      end else if (!Stall) begin
        m_valid = 0; m_addr = m_pc; m_req = 1;
      end
    end else if (!m_req) begin
      m_req = 1;
      if (Redirect) begin m_pc = tgt; m_addr = tgt; end
    end else if (IMemAck) begin
      m_wait = 0;
      if (Redirect) begin
        m_pc = tgt; m_addr = tgt; m_stale = 0;
      end else if (m_stale) begin
        m_addr = m_pc; m_stale = 0;
      end else begin
        m_instr = IMemData; m_ipc = m_addr; m_valid = 1; m_pc = m_pc + 32'd4; m_req = 0;
      end
    end else if (Redirect) begin
      m_pc = tgt; m_stale = 1; m_wait = 0;
    end else begin
      if (m_wait < int'(LIMIT)) m_wait++;
      if (m_wait == int'(LIMIT)) m_err = 1;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge Clk) begin
    chk("m_PCResult", PCResult, m_pc);
    chk("m_IMemReq", 32'(IMemReq), 32'(m_req));
    chk("m_IMemAddr", IMemAddr, m_addr);
    chk("m_InstrValid", 32'(InstrValid), 32'(m_valid));
    chk("m_Instruction", Instruction, m_instr);
    chk("m_InstrPC", InstrPC, m_ipc);
    chk("m_FetchErr", 32'(FetchErr), 32'(m_err));
  end

  // One clock of stimulus; memory returns its address as data
  task automatic cyc(input logic ack, input logic stall, input logic redir, input logic [31:0] tgt);
    IMemAck = ack; Stall = stall; Redirect = redir; RedirectPC = tgt;
    IMemData = IMemAddr;
    @(negedge Clk);
  endtask

  // Asynchronous reset pulse starting mid-cycle; a stale ack follows release
  task automatic do_reset();
    #2 Reset = 1'b0;
    #1;
    chk("rst_IMemReq", 32'(IMemReq), 32'd0);
    chk("rst_FetchErr", 32'(FetchErr), 32'd0);
    chk("rst_InstrValid", 32'(InstrValid), 32'd0);
    chk("rst_PCResult", PCResult, 32'h0);
    chk("rst_IMemAddr", IMemAddr, 32'h0);
    Redirect = 0; Stall = 0; IMemAck = 0;
    @(negedge Clk);
    @(negedge Clk);
    IMemAck = 1'b1; IMemData = 32'hDEAD_BEEF;
    #2 Reset = 1'b1;
    @(negedge Clk);
    IMemAck = 1'b0;
    chk("rel_IMemReq", 32'(IMemReq), 32'd1);
    chk("rel_IMemAddr", IMemAddr, 32'h0);
    chk("rel_stale_ack", 32'(InstrValid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge Clk);
    do_reset();

    // Sequential fetch, 1-cycle ack, no stall
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0);
      chk("seq_gap", 32'(InstrValid), 32'd0);
      cyc(1, 0, 0, 0);
      chk("seq_valid", 32'(InstrValid), 32'd1);
      chk("seq_pc", InstrPC, 32'(k * 4));
      chk("seq_data", Instruction, 32'(k * 4));
      cyc(0, 0, 0, 0);
      chk("seq_next_addr", IMemAddr, 32'((k + 1) * 4));
    end

    // Stall in HOLD on 0x4
    @(negedge Clk);
    do_reset();
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0); cyc(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(i == 2, 1, 0, 0);
      chk("stall_valid", 32'(InstrValid), 32'd1);
      chk("stall_pc", InstrPC, 32'h4);
      chk("stall_data", Instruction, 32'h4);
      chk("stall_req", 32'(IMemReq), 32'd0);
    end
    cyc(0, 0, 0, 0);
    chk("unstall_addr", IMemAddr, 32'h8);

    // Redirect to 0x40 while 0x8 is outstanding, ack 3 cycles later
    cyc(0, 0, 1, 32'h40);
    chk("drop_addr", IMemAddr, 32'h8);
    chk("drop_pc", PCResult, 32'h40);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("drop_hold_addr", IMemAddr, 32'h8);
    cyc(1, 0, 0, 0);
    chk("drop_discard", 32'(InstrValid), 32'd0);
    chk("drop_new_addr", IMemAddr, 32'h40);
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("redir_ipc", InstrPC, 32'h40);
    chk("redir_pc", PCResult, 32'h44);

    // Redirect in HOLD overrides Stall; target low bits cleared
    cyc(0, 1, 1, 32'h43);
    chk("hold_redir_valid", 32'(InstrValid), 32'd0);
    chk("hold_redir_addr", IMemAddr, 32'h40);
    // Redirect together with ack in FETCH
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 32'h80);
    chk("ackredir_valid", 32'(InstrValid), 32'd0);
    chk("ackredir_addr", IMemAddr, 32'h80);
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("ackredir_ipc", InstrPC, 32'h80);
    cyc(0, 0, 0, 0);

    // Timeout: no ack for LIMIT cycles
    for (int i = 1; i < int'(LIMIT); i++) begin
      cyc(0, 0, 0, 0);
      chk("tmo_early", 32'(FetchErr), 32'd0);
    end
    cyc(0, 0, 0, 0);
    chk("tmo_set", 32'(FetchErr), 32'd1);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("tmo_sticky", 32'(FetchErr), 32'd1);
    chk("tmo_late_ipc", InstrPC, 32'h84);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    do_reset();

    // PC wrap and redirect alignment
    cyc(0, 0, 1, 32'hFFFF_FFFF);
    chk("wrap_pc", PCResult, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    chk("wrap_addr", IMemAddr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("wrap_ipc", InstrPC, 32'hFFFF_FFFC);
    chk("wrap_next_pc", PCResult, 32'h0);
    cyc(0, 0, 0, 0);
    chk("wrap_next_addr", IMemAddr, 32'h0);
    cyc(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
